// File: rtl/sys_feeder.sv
// sys_feeder: holds one operand tile and streams it diagonally skewed into an
// output-stationary systolic array after a one-cycle array clear.
module sys_feeder #(
    parameter int DEP  = 8,
    parameter int ROW  = 2,
    parameter int COL  = 2,
    parameter int KMAX = 4,
    localparam int MX   = (ROW > COL) ? ROW : COL,
    localparam int LW   = (MX > 1) ? $clog2(MX) : 1,
    localparam int KW   = (KMAX > 1) ? $clog2(KMAX) : 1,
    localparam int LENW = $clog2(KMAX + 1),
    localparam int TW   = $clog2(KMAX + MX + ROW + COL)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [LW-1:0]   wr_lane,
    input  logic [KW-1:0]   wr_k,
    input  logic [DEP-1:0]  wr_data,
    input  logic            start,
    input  logic [LENW-1:0] k_len,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [DEP-1:0]  x_out [0:COL-1],
    output logic [DEP-1:0]  w_out [0:ROW-1],
    output logic            arr_rst
);
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_FIN} state_t;

    state_t          r_state;
    logic [DEP-1:0]  r_x [COL][KMAX];
    logic [DEP-1:0]  r_w [ROW][KMAX];
    logic [LENW-1:0] r_k;
    logic [TW-1:0]   r_t;
    logic            r_busy, r_done, r_err, r_clr;
    logic [DEP-1:0]  r_xo [COL];
    logic [DEP-1:0]  r_wo [ROW];

    logic [TW-1:0]   w_n, w_s_last, w_d_last;
    logic [DEP-1:0]  w_xn [COL];
    logic [DEP-1:0]  w_wn [ROW];
    logic            w_kok, w_wr;

    // w_n is the stream index the outputs will carry after the next edge
    assign w_n      = (r_state == S_CLEAR) ? '0 : r_t + 1'b1;
    assign w_s_last = TW'(int'(r_k) + MX - 2);
    assign w_d_last = TW'(ROW + COL - 2);
    assign w_kok    = (k_len != '0) && (int'(k_len) <= KMAX);
    assign w_wr     = wr_en && (r_state == S_IDLE) && (int'(wr_k) < KMAX) &&
                      (int'(wr_lane) < (wr_sel ? ROW : COL));

    always_comb begin
        for (int j = 0; j < COL; j++)
            w_xn[j] = (int'(w_n) >= j && int'(w_n) - j < int'(r_k)) ? r_x[j][KW'(int'(w_n) - j)] : '0;
        for (int i = 0; i < ROW; i++)
            w_wn[i] = (int'(w_n) >= i && int'(w_n) - i < int'(r_k)) ? r_w[i][KW'(int'(w_n) - i)] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_x     <= '{default: '0};
            r_w     <= '{default: '0};
            r_k     <= '0;
            r_t     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_clr   <= 1'b0;
            r_xo    <= '{default: '0};
            r_wo    <= '{default: '0};
        end else begin
            r_err <= 1'b0;
            if (w_wr && wr_sel)
                r_w[wr_lane][wr_k] <= wr_data;
            if (w_wr && !wr_sel)
                r_x[wr_lane][wr_k] <= wr_data;
            case (r_state)
                S_IDLE: begin
                    if (start && w_kok) begin
                        r_state <= S_CLEAR;
                        r_k     <= k_len;
                        r_clr   <= 1'b1;
                        r_busy  <= 1'b1;
                    end else if (start) begin
                        r_err <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_state <= S_STREAM;
                    r_t     <= '0;
                    r_clr   <= 1'b0;
                    r_xo    <= w_xn;
                    r_wo    <= w_wn;
                end
                S_STREAM: begin
                    if (r_t == w_s_last) begin
                        r_state <= S_DRAIN;
                        r_t     <= '0;
                        r_xo    <= '{default: '0};
                        r_wo    <= '{default: '0};
                    end else begin
                        r_t  <= r_t + 1'b1;
                        r_xo <= w_xn;
                        r_wo <= w_wn;
                    end
                end
                S_DRAIN: begin
                    if (r_t == w_d_last) begin
                        r_state <= S_FIN;
                        r_t     <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_t <= r_t + 1'b1;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign x_out   = r_xo;
    assign w_out   = r_wo;
    assign arr_rst = rst | r_clr;
endmodule

// File: tb/tb_sys_feeder.sv
// tb_sys_feeder: directed scoreboard bench for sys_feeder (ROW=COL=2, KMAX=4).
module tb_sys_feeder;
    logic       clk = 0, rst = 0, wr_en = 0, wr_sel = 0, start = 0;
    logic [0:0] wr_lane = '0;
    logic [1:0] wr_k = '0;
    logic [7:0] wr_data = '0;
    logic [2:0] k_len = '0;
    logic       busy, done, err, arr_rst;
    logic [7:0] x_out [0:1];
    logic [7:0] w_out [0:1];

    typedef struct packed {
        logic       ar, busy, done, err;
        logic [7:0] x0, x1, w0, w1;
    } exp_t;

    exp_t       q[$];
    logic [7:0] mx [2][4];
    logic [7:0] mw [2][4];
    int         checks = 0, errors = 0;

    sys_feeder #(.DEP(8), .ROW(2), .COL(2), .KMAX(4)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_lane(wr_lane),
        .wr_k(wr_k), .wr_data(wr_data), .start(start), .k_len(k_len),
        .busy(busy), .done(done), .err(err), .x_out(x_out), .w_out(w_out),
        .arr_rst(arr_rst)
    );

    always #5 clk = ~clk;

    task automatic chk(input exp_t e, input string tag);
        exp_t o;
        o = '{arr_rst, busy, done, err, x_out[0], x_out[1], w_out[0], w_out[1]};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] mv(input bit s, input int l, input int i, input int k);
        return (i >= 0 && i < k) ? (s ? mw[l][i] : mx[l][i]) : 8'd0;
    endfunction

    task automatic push_run(input int k);
        exp_t e;
        e = '0; e.ar = 1; e.busy = 1; q.push_back(e);
        for (int t = 0; t < k + 1; t++) begin
            e = '0; e.busy = 1;
            e.x0 = mv(0, 0, t, k); e.x1 = mv(0, 1, t - 1, k);
            e.w0 = mv(1, 0, t, k); e.w1 = mv(1, 1, t - 1, k);
            q.push_back(e);
        end
        for (int d = 0; d < 3; d++) begin
            e = '0; e.busy = 1; q.push_back(e);
        end
        e = '0; e.done = 1; q.push_back(e);
    endtask

    task automatic push_idle();
        q.push_back(exp_t'(0));
    endtask

    task automatic wr(input bit s, input int l, input int i, input logic [7:0] d);
        wr_en = 1; wr_sel = s; wr_lane = l[0:0]; wr_k = i[1:0]; wr_data = d;
        step();
        wr_en = 0;
        if (s) mw[l][i] = d; else mx[l][i] = d;
    endtask

    task automatic clr_model();
        for (int l = 0; l < 2; l++)
            for (int i = 0; i < 4; i++) begin
                mx[l][i] = '0;
                mw[l][i] = '0;
            end
    endtask

    task automatic load1();
        wr(0, 0, 0, 1); wr(0, 0, 1, 2); wr(0, 1, 0, 3); wr(0, 1, 1, 4);
        wr(1, 0, 0, 5); wr(1, 0, 1, 6); wr(1, 1, 0, 7); wr(1, 1, 1, 8);
    endtask

    // pops one expectation per cycle; start held for 'hold' cycles, stray X0[0]=9 write at 'inj'
    task automatic run(input int k, input int hold, input int inj, input string tag);
        int n;
        n = 0;
        k_len = k[2:0];
        start = 1;
        step();
        while (q.size() != 0) begin
            if (n + 1 >= hold) start = 0;
            wr_en = (n == inj); wr_sel = 0; wr_lane = '0; wr_k = '0; wr_data = 8'd9;
            chk(q.pop_front(), $sformatf("%s c%0d", tag, n + 1));
            n++;
            step();
        end
        start = 0;
        wr_en = 0;
    endtask

    initial begin
        exp_t e;
        clr_model();
        #1 rst = 1;
        #10;
        e = '0; e.ar = 1;
        chk(e, "reset_hold");
        rst = 0;
        step();
        chk(exp_t'(0), "reset_idle");

        load1();
        push_run(2); push_idle();
        run(2, 1, -1, "t1");

        k_len = 3'd0; start = 1; step(); start = 0;
        e = '0; e.err = 1; chk(e, "err_k0");
        step(); chk(exp_t'(0), "err_k0_clear");
        k_len = 3'd5; start = 1; step(); start = 0;
        chk(e, "err_k5");
        step(); chk(exp_t'(0), "err_k5_clear");

        push_run(2); push_idle();
        run(2, 1, 1, "t3_write");
        push_run(2); push_idle();
        run(2, 1, -1, "t3_rerun");

        push_run(2);
        k_len = 3'd2; start = 1; step(); start = 0;
        chk(q.pop_front(), "t4 c1");
        step(); chk(q.pop_front(), "t4 c2");
        step(); chk(q.pop_front(), "t4 c3");
        #2 rst = 1;
        #1;
        e = '0; e.ar = 1;
        chk(e, "t4_async_rst");
        step(); chk(e, "t4_rst_held");
        rst = 0;
        #1 chk(exp_t'(0), "t4_released");
        q.delete();
        clr_model();
        step();
        push_run(2); push_idle();
        run(2, 1, -1, "t4_cleared");
        load1();
        push_run(2); push_idle();
        run(2, 1, -1, "t4_rerun");

        push_run(2); push_idle(); push_run(2); push_idle();
        run(2, 10, -1, "t5");

        wr(0, 0, 0, 1); wr(0, 0, 1, 2); wr(0, 0, 2, 3); wr(0, 0, 3, 4);
        wr(0, 1, 0, 5); wr(0, 1, 1, 6); wr(0, 1, 2, 7); wr(0, 1, 3, 8);
        wr(1, 0, 2, 11); wr(1, 0, 3, 12); wr(1, 1, 2, 21); wr(1, 1, 3, 22);
        push_run(4); push_idle();
        run(4, 1, -1, "t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
